i2c_slave_fsm: RTL
==================

# i2c_slave_fsm

Protocol state machine for the I2C register-access slave. It synchronises the raw SCL/SDA pad inputs and detects START/STOP conditions. It sequences device-address, register-address, write and read phases and drives the register-file read/write port. Downstream, `I2C_signals` consumes its `state`, `data_index` and `read_value` outputs and drives the SDA/SCL pad enables on SCL falling edges.

## Interface
- `DEV_ADDR`, 7'h42, 7-bit slave address matched against the first byte
- `NUM_REGS`, 8, number of addressable registers (1..256); register pointer wraps at NUM_REGS-1
- `clk` in 1: system clock; ≥10× SCL frequency
- `rst_n` in 1: synchronous, active-low reset
- `ena` in 1: block enable; when low all registers hold and `wr_en` is 0
- `SCL_in` in 1: raw SCL pad input (asynchronous)
- `SDA_in` in 1: raw SDA pad input (asynchronous)
- `state` out 5: current protocol state, encoding below
- `data_index` out 3: bit index of the current data/read bit, MSB first (7→0)
- `read_value` out 8: byte being returned to the master
- `rd_addr` out 8: register read address (= register pointer)
- `rd_data` in 8: combinational register-file read data for `rd_addr`
- `wr_en` out 1: one-clk register write strobe
- `wr_addr` out 8: write address
- `wr_data` out 8: write data

## Operation
- State encoding (fixed, shared with downstream): IDLE=0, START=1, DEVICE_ADDR=2, READ_OR_WRITE=3, ADDR_ACK=4, REG_ADDR=5, REG_ACK=6, WRITE=7, WRITE_ACK=8, READ=9, READ_ACK=10, STOP=11. Codes 12–31 are never produced and recover to IDLE.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchroniser, then a `prev` register.
  - SCL rise: sync=1, prev=0.
  - START condition: SCL sync and prev both 1, SDA falls.
  - STOP condition: SCL sync and prev both 1, SDA rises.
  - An SDA edge in the same cycle as an SCL edge is not a START/STOP.
- START condition from any state → START. The register pointer is retained, so a repeated START can follow a register-address write.
- STOP condition from any state → STOP. STOP holds until the next START condition.
- All other transitions occur only on SCL rise, sampling synchronised SDA:
  - START: shift addr bit 6 → DEVICE_ADDR.
  - DEVICE_ADDR: shift next bit; after addr bit 0 is sampled → READ_OR_WRITE.
  - READ_OR_WRITE: sample R/W. If address equals DEV_ADDR → ADDR_ACK (latch R/W); otherwise → IDLE.
  - ADDR_ACK, R/W=0: → REG_ADDR, `data_index`=7.
  - ADDR_ACK, R/W=1: → READ, `data_index`=7, `read_value`←`rd_data`.
  - REG_ADDR: shift bit into the address shift register and decrement `data_index`. After bit 0 → REG_ACK, pointer ← received byte mod NUM_REGS.
  - REG_ACK: → WRITE, `data_index`=7.
  - WRITE: shift data bit and decrement `data_index`. After bit 0 → WRITE_ACK and pulse `wr_en` for one clk, with `wr_addr`=pointer and `wr_data`=received byte.
  - WRITE_ACK: pointer+1 (wrap NUM_REGS-1→0) → WRITE, `data_index`=7.
  - READ: decrement `data_index`. After bit 0 is clocked → READ_ACK.
  - READ_ACK: master ACK/NACK is not inspected. Pointer+1 (wrap), `read_value`←`rd_data` at the new pointer → READ, `data_index`=7.
- In IDLE, SCL rises are ignored.
- `rd_addr` always equals the pointer.

## Timing
- Reset values: `state`=IDLE, `data_index`=7, `read_value`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, pointer/`rd_addr`=0. Shift registers and synchronisers are cleared to 1 (bus idle).
- Latency: a pad edge meeting setup before clk edge k updates outputs at edge k+2.
- `state` is therefore stable well before the next SCL fall, where downstream acts.
- `wr_en` asserts at the same edge `state` becomes WRITE_ACK and deasserts the next clk.
- `read_value` updates in the same cycle `state` enters READ.
- Reset mid-transaction: IDLE immediately; no `wr_en` is issued for a partial byte.
- STOP or START mid-byte: the partial byte is discarded and no write occurs.

## Test plan
- Write: START, addr 0x42+W, reg 0x03, data 0xA5, STOP → state sequence 1,2,3,4,5,6,7,8,7,11; single `wr_en` with `wr_addr`=3, `wr_data`=0xA5.
- Burst read: regs 2..3 = 0x11,0x22; write reg addr 2, repeated START, 0x42+R, read 2 bytes → `read_value` 0x11 then 0x22; `data_index` 7→0 per byte.
- Address mismatch: START, 0x43+W → IDLE after R/W bit; `wr_en` never asserts; no state change until the next START.
- Pointer wrap: NUM_REGS=8, reg addr 7, write 0x01,0x02 → writes to addr 7 then 0.
- STOP after 4 data bits of a write → state STOP, no `wr_en`.
- `rst_n` low for 1 clk during WRITE → all outputs at reset values the next clk; a subsequent full write completes normally.

Source files
------------

// File: rtl/i2c_slave_fsm.sv
// I2C register-access slave protocol FSM: pad synchronisation, START/STOP
// detection, address/register/data phase sequencing and register-file port.
module i2c_slave_fsm #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic [4:0] state,
  output logic [2:0] data_index,
  output logic [7:0] read_value,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [4:0] {
    ST_IDLE          = 5'd0,
    ST_START         = 5'd1,
    ST_DEVICE_ADDR   = 5'd2,
    ST_READ_OR_WRITE = 5'd3,
    ST_ADDR_ACK      = 5'd4,
    ST_REG_ADDR      = 5'd5,
    ST_REG_ACK       = 5'd6,
    ST_WRITE         = 5'd7,
    ST_WRITE_ACK     = 5'd8,
    ST_READ          = 5'd9,
    ST_READ_ACK      = 5'd10,
    ST_STOP          = 5'd11
  } state_t;

  localparam logic [7:0] PTR_MAX = 8'(NUM_REGS - 1);
  localparam logic [8:0] NREGS   = 9'(NUM_REGS);

  // Synchroniser and edge-history registers (idle bus level is 1).
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Protocol state.
  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] read_value_q, read_value_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  // Decoded bus events.
  logic       scl_rise;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] rx_byte;
  logic [7:0] ptr_inc;

  // Both SCL samples high means SCL is stable, so an SDA edge then is START/STOP.
  assign scl_rise   = scl_sync_q & ~scl_prev_q;
  assign start_cond = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_cond  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign rx_byte    = {shift_q[6:0], sda_sync_q};
  assign ptr_inc    = (ptr_q == PTR_MAX) ? 8'd0 : (ptr_q + 8'd1);

  // Pad synchronisers and previous-sample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else if (ena) begin
      scl_meta_q <= SCL_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= SDA_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Next-state and datapath decode; START/STOP override everything else.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    ptr_d        = ptr_q;
    read_value_d = read_value_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (start_cond) begin
      state_d = ST_START;
      idx_d   = 3'd7;
      shift_d = 8'hFF;
    end else if (stop_cond) begin
      state_d = ST_STOP;
      idx_d   = 3'd7;
    end else if (scl_rise) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_START: begin
          // Address bit 6 sampled here; idx tracks the next address bit.
          shift_d = rx_byte;
          idx_d   = 3'd5;
          state_d = ST_DEVICE_ADDR;
        end
        ST_DEVICE_ADDR: begin
          shift_d = rx_byte;
          if (idx_q == 3'd0) begin
            state_d = ST_READ_OR_WRITE;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        ST_READ_OR_WRITE: begin
          if (shift_q[6:0] == DEV_ADDR) begin
            rw_d    = sda_sync_q;
            state_d = ST_ADDR_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR_ACK: begin
          idx_d = 3'd7;
          if (rw_q) begin
            read_value_d = rd_data;
            state_d      = ST_READ;
          end else begin
            state_d = ST_REG_ADDR;
          end
        end
        ST_REG_ADDR: begin
          shift_d = rx_byte;
          if (idx_q == 3'd0) begin
            ptr_d   = 8'({1'b0, rx_byte} % NREGS);
            state_d = ST_REG_ACK;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        ST_REG_ACK: begin
          idx_d   = 3'd7;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          shift_d = rx_byte;
          if (idx_q == 3'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_byte;
            state_d   = ST_WRITE_ACK;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        ST_WRITE_ACK: begin
          ptr_d   = ptr_inc;
          idx_d   = 3'd7;
          state_d = ST_WRITE;
        end
        ST_READ: begin
          if (idx_q == 3'd0) begin
            // Advance the pointer one phase early so the combinational
            // rd_data already reflects the next register when the ACK
            // clock loads read_value.
            ptr_d   = ptr_inc;
            state_d = ST_READ_ACK;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
        ST_READ_ACK: begin
          read_value_d = rd_data;
          idx_d        = 3'd7;
          state_d      = ST_READ;
        end
        ST_STOP: begin
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q > ST_STOP) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Protocol state registers; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd7;
      shift_q      <= 8'hFF;
      rw_q         <= 1'b0;
      ptr_q        <= 8'd0;
      read_value_q <= 8'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
    end else if (ena) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      ptr_q        <= ptr_d;
      read_value_q <= read_value_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign state      = state_q;
  assign data_index = idx_q;
  assign read_value = read_value_q;
  assign rd_addr    = ptr_q;
  assign wr_en      = wr_en_q & ena;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule
